// File: rtl/alu_issue_pkg.sv
// Shared types and field definitions for the ALU issue front end.
package alu_issue_pkg;

  localparam int A_SEL_W = 2;
  localparam int B_SEL_W = 2;
  localparam int CTRL_W  = 5;
  localparam int DATA_W  = 32;

  // Bit positions inside the captured {cout, overflow, zero} flag vector.
  localparam int FLAG_COUT = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 0;
  localparam int FLAGS_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPTURE,
    HOLD
  } state_e;

endpackage

// File: rtl/alu_issue_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the ALU: registers ROM addresses, waits for the datapath
// to settle, captures result/flags and hands them downstream.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_SEL_W-1:0] in_a_sel,
  input  logic [B_SEL_W-1:0] in_b_sel,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic [A_SEL_W-1:0] oner_addr,
  output logic [B_SEL_W-1:0] twor_addr,
  output logic [CTRL_W-1:0]  threer_addr,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_cout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [CNT_W-1:0]   op_count,
  output logic [CNT_W-1:0]   ovf_count
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           settle_q, settle_d;
  logic [A_SEL_W-1:0]   oner_q, oner_d;
  logic [B_SEL_W-1:0]   twor_q, twor_d;
  logic [CTRL_W-1:0]    threer_q, threer_d;
  logic [DATA_W-1:0]    out_result_q, out_result_d;
  logic [FLAGS_W-1:0]   out_flags_q, out_flags_d;
  logic [FLAGS_W-1:0]   alu_flags;
  logic                 capture;

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLAG_COUT] = alu_cout;
    alu_flags[FLAG_OVF]  = alu_overflow;
    alu_flags[FLAG_ZERO] = alu_zero;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    oner_d       = oner_q;
    twor_d       = twor_q;
    threer_d     = threer_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          oner_d   = in_a_sel;
          twor_d   = in_b_sel;
          threer_d = in_ctrl;
          settle_d = SETTLE_INIT;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (settle_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CAPTURE: begin
        capture      = 1'b1;
        out_result_d = alu_result;
        out_flags_d  = alu_flags;
        state_d      = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      oner_q       <= '0;
      twor_q       <= '0;
      threer_q     <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      oner_q       <= oner_d;
      twor_q       <= twor_d;
      threer_q     <= threer_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign oner_addr   = oner_q;
  assign twor_addr   = twor_q;
  assign threer_addr = threer_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;

  sat_counter #(.WIDTH(CNT_W)) u_op_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (capture),
    .count_o (op_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (capture && alu_overflow),
    .count_o (ovf_count)
  );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: default, long-settle and narrow-counter instances.
module tb_alu_issue_unit;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid [N];
  logic        in_ready [N];
  logic        out_valid[N];
  logic        out_ready[N];
  logic [1:0]  a_sel    [N];
  logic [1:0]  b_sel    [N];
  logic [1:0]  oner     [N];
  logic [1:0]  twor     [N];
  logic [4:0]  ctrl     [N];
  logic [4:0]  threer   [N];
  logic [31:0] alu_res  [N];
  logic [31:0] out_res  [N];
  logic [2:0]  alu_fl   [N];  // {cout, overflow, zero}
  logic [2:0]  out_fl   [N];
  logic [15:0] op_cnt   [2];
  logic [15:0] ovf_cnt  [2];
  logic [2:0]  op_cnt_c3, ovf_cnt_c3;

  alu_issue_unit #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a_sel(a_sel[0]), .in_b_sel(b_sel[0]), .in_ctrl(ctrl[0]),
    .oner_addr(oner[0]), .twor_addr(twor[0]), .threer_addr(threer[0]),
    .alu_result(alu_res[0]), .alu_cout(alu_fl[0][2]),
    .alu_overflow(alu_fl[0][1]), .alu_zero(alu_fl[0][0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_res[0]), .out_flags(out_fl[0]),
    .op_count(op_cnt[0]), .ovf_count(ovf_cnt[0])
  );

  alu_issue_unit #(.SETTLE_CYCLES(4), .CNT_W(16)) u_dut_s4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a_sel(a_sel[1]), .in_b_sel(b_sel[1]), .in_ctrl(ctrl[1]),
    .oner_addr(oner[1]), .twor_addr(twor[1]), .threer_addr(threer[1]),
    .alu_result(alu_res[1]), .alu_cout(alu_fl[1][2]),
    .alu_overflow(alu_fl[1][1]), .alu_zero(alu_fl[1][0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(out_res[1]), .out_flags(out_fl[1]),
    .op_count(op_cnt[1]), .ovf_count(ovf_cnt[1])
  );

  alu_issue_unit #(.SETTLE_CYCLES(1), .CNT_W(3)) u_dut_c3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a_sel(a_sel[2]), .in_b_sel(b_sel[2]), .in_ctrl(ctrl[2]),
    .oner_addr(oner[2]), .twor_addr(twor[2]), .threer_addr(threer[2]),
    .alu_result(alu_res[2]), .alu_cout(alu_fl[2][2]),
    .alu_overflow(alu_fl[2][1]), .alu_zero(alu_fl[2][0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_result(out_res[2]), .out_flags(out_fl[2]),
    .op_count(op_cnt_c3), .ovf_count(ovf_cnt_c3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) at falling edges until out_valid of instance k is high.
  task automatic wait_valid(input int k);
    int n = 0;
    @(negedge clk);
    while (!out_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_valid", 32'(out_valid[k]), 32'd1);
  endtask

  // Called just after a rising edge with instance k idle; returns just after the transfer edge.
  task automatic do_op(input int k, input logic [1:0] a, input logic [1:0] b,
                       input logic [4:0] c, input logic [31:0] res, input logic [2:0] fl,
                       output logic [31:0] got_res, output logic [2:0] got_fl);
    a_sel[k]    = a;
    b_sel[k]    = b;
    ctrl[k]     = c;
    alu_res[k]  = res;
    alu_fl[k]   = fl;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    wait_valid(k);
    got_res      = out_res[k];
    got_fl       = out_fl[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [1:0]  b;
    logic [4:0]  ctrl;
    logic [31:0] res;
    logic [2:0]  fl;
    logic [15:0] exp_op;
    logic [15:0] exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  f;

    // Two earlier ops (counts 1 and 2, no overflow) precede this table; only ctrl 01001 (sub) overflows.
    vecs[0] = '{2'd1, 2'd2, 5'b00001, 32'h0000_0003, 3'b000, 16'd3, 16'd0};
    vecs[1] = '{2'd2, 2'd3, 5'b01000, 32'hFFFF_FFFF, 3'b100, 16'd4, 16'd0};
    vecs[2] = '{2'd3, 2'd0, 5'b01001, 32'h8000_0000, 3'b010, 16'd5, 16'd1};
    vecs[3] = '{2'd0, 2'd0, 5'b10000, 32'h0000_0000, 3'b001, 16'd6, 16'd1};
    vecs[4] = '{2'd1, 2'd1, 5'b10111, 32'h0000_00AA, 3'b000, 16'd7, 16'd1};
    vecs[5] = '{2'd2, 2'd1, 5'b11110, 32'h1234_5678, 3'b100, 16'd8, 16'd1};

    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a_sel[k] = '0; b_sel[k] = '0; ctrl[k] = '0;
      alu_res[k] = '0; alu_fl[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_result", out_res[0], 32'd0);
    check("rst_out_flags", 32'(out_fl[0]), 32'd0);
    check("rst_addrs", 32'({oner[0], twor[0], threer[0]}), 32'd0);
    check("rst_counts", {op_cnt[0], ovf_cnt[0]}, 32'd0);

    // Single op with full cycle-by-cycle timing.
    @(posedge clk); #1;
    a_sel[0] = 2'b00; b_sel[0] = 2'b01; ctrl[0] = 5'b00001;
    alu_res[0] = 32'h0000_00F0; alu_fl[0] = 3'b001; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; a_sel[0] = 2'b11; b_sel[0] = 2'b11; ctrl[0] = 5'h1F;
    @(negedge clk);
    check("a1_addrs", 32'({oner[0], twor[0], threer[0]}), 32'({2'b00, 2'b01, 5'b00001}));
    check("a1_in_ready", 32'(in_ready[0]), 32'd0);
    check("a1_out_valid", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("a2_out_valid", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("a3_out_valid", 32'(out_valid[0]), 32'd1);
    check("a3_out_result", out_res[0], 32'h0000_00F0);
    check("a3_out_flags", 32'(out_fl[0]), 32'd1);
    check("a3_op_count", 32'(op_cnt[0]), 32'd1);
    check("a3_addrs_stable", 32'({oner[0], twor[0], threer[0]}), 32'({2'b00, 2'b01, 5'b00001}));

    // Back-pressure: a new request and a changing ALU value must not disturb HOLD.
    @(posedge clk); #1;
    a_sel[0] = 2'd3; b_sel[0] = 2'd2; ctrl[0] = 5'b01010;
    alu_res[0] = 32'hDEAD_BEEF; alu_fl[0] = 3'b000; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result", out_res[0], 32'h0000_00F0);
      check("bp_valid_ready", 32'({out_valid[0], in_ready[0]}), 32'b10);
      check("bp_addrs", 32'({oner[0], twor[0], threer[0]}), 32'({2'b00, 2'b01, 5'b00001}));
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("xfer_valid", 32'(out_valid[0]), 32'd1);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("post_xfer_ready_valid", 32'({in_ready[0], out_valid[0]}), 32'b10);
    check("post_xfer_count", 32'(op_cnt[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("second_addrs", 32'({oner[0], twor[0], threer[0]}), 32'({2'd3, 2'd2, 5'b01010}));
    wait_valid(0);
    check("second_result", out_res[0], 32'hDEAD_BEEF);
    check("second_count", 32'(op_cnt[0]), 32'd2);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Table-driven ops with overflow counting.
    for (int i = 0; i < 6; i++) begin
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].res, vecs[i].fl, r, f);
      check("tbl_result", r, vecs[i].res);
      check("tbl_flags", 32'(f), 32'(vecs[i].fl));
      check("tbl_addrs", 32'({oner[0], twor[0], threer[0]}),
            32'({vecs[i].a, vecs[i].b, vecs[i].ctrl}));
      check("tbl_op_count", 32'(op_cnt[0]), 32'(vecs[i].exp_op));
      check("tbl_ovf_count", 32'(ovf_cnt[0]), 32'(vecs[i].exp_ovf));
    end

    // SETTLE_CYCLES = 4: value changed two cycles after accept is the one captured.
    a_sel[1] = 2'd1; b_sel[1] = 2'd2; ctrl[1] = 5'd3;
    alu_res[1] = 32'h1111_1111; alu_fl[1] = 3'b000; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    alu_res[1] = 32'h2222_2222; alu_fl[1] = 3'b100;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("s4_a5_valid", 32'(out_valid[1]), 32'd0);
    @(negedge clk);
    check("s4_a6_valid", 32'(out_valid[1]), 32'd1);
    check("s4_result", out_res[1], 32'h2222_2222);
    check("s4_flags", 32'(out_fl[1]), 32'b100);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // CNT_W = 3: nine overflowing ops saturate both counters at 7.
    for (int i = 1; i <= 9; i++) begin
      do_op(2, 2'(i), 2'(i + 1), 5'(i), 32'(i), 3'b010, r, f);
      check("sat_result", r, 32'(i));
      check("sat_op_count", 32'(op_cnt_c3), 32'((i > 7) ? 7 : i));
      check("sat_ovf_count", 32'(ovf_cnt_c3), 32'((i > 7) ? 7 : i));
    end

    // Reset in the middle of EXEC discards the operation.
    a_sel[0] = 2'd2; b_sel[0] = 2'd3; ctrl[0] = 5'b00111;
    alu_res[0] = 32'h5555_5555; alu_fl[0] = 3'b010; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("mid_exec_ready", 32'(in_ready[0]), 32'd0);
    check("mid_exec_count", 32'(op_cnt[0]), 32'd8);
    #1 rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("mrst_addrs", 32'({oner[0], twor[0], threer[0]}), 32'd0);
    check("mrst_counts", {op_cnt[0], ovf_cnt[0]}, 32'd0);
    check("mrst_out_result", out_res[0], 32'd0);
    check("mrst_c3_counts", 32'({op_cnt_c3, ovf_cnt_c3}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready[0]), 32'd1);
    repeat (4) @(negedge clk);
    check("rel_no_result", 32'(out_valid[0]), 32'd0);
    check("rel_count", 32'(op_cnt[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
